// File: rtl/pixel_writer.sv
// Buffers rasterized pixels in a FIFO and writes them to a linear framebuffer.
// A clear request sweeps CLEAR_COLOR over the whole frame before draining resumes.
module pixel_writer #(
  parameter int unsigned WIDTH       = 1024,
  parameter int unsigned HEIGHT      = 720,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000,
  localparam int unsigned AW         = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          clear_in,
  input  logic          valid_in,
  input  logic [19:0]   pixel_in,
  input  logic [23:0]   color_in,
  input  logic          last_in,
  output logic          ready_out,
  output logic [AW-1:0] addr_out,
  output logic [23:0]   data_out,
  output logic          we_out,
  output logic          done_out,
  output logic          busy_out
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PW + 1;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] color;
    logic        last;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [23:0]   data_q, data_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        entry_in_c;
  entry_t        head_c;
  logic          full_c;
  logic          empty_c;
  logic          push_c;
  logic          pop_c;
  logic          in_bounds_c;
  logic [AW-1:0] lin_addr_c;

  assign entry_in_c = {pixel_in, color_in, last_in};
  assign full_c     = (count_q == CW'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign ready_out  = !full_c;

  // Next-state, FIFO bookkeeping and framebuffer write generation
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    clr_cnt_d = clr_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    done_d    = 1'b0;

    push_c = valid_in && !full_c;
    pop_c  = (state_q == DRAIN) && !empty_c;

    head_c      = mem_q[rd_ptr_q];
    in_bounds_c = (32'(head_c.x) < WIDTH) && (32'(head_c.y) < HEIGHT);
    // In-bounds coordinates always land below WIDTH*HEIGHT, so AW bits hold the full result
    lin_addr_c  = AW'(head_c.x) + AW'(head_c.y) * AW'(WIDTH);

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);

    case (state_q)
      IDLE: begin
        if (clear_in) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (!empty_c) begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        data_d    = CLEAR_COLOR;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NPIX - 1)) begin
          clr_cnt_d = '0;
          state_d   = (count_d != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (pop_c) begin
          we_d   = in_bounds_c;
          done_d = head_c.last;
          if (in_bounds_c) begin
            addr_d = lin_addr_c;
            data_d = head_c.color;
          end
        end
        if (count_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  // Control and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Payload storage needs no reset; the pointers define which entries are live
  always_ff @(posedge clk_in) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= entry_in_c;
    end
  end

  assign addr_out = addr_q;
  assign data_out = data_q;
  assign we_out   = we_q;
  assign done_out = done_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a 1024x4 instance for addressing/FIFO behaviour
// and a 4x2 instance for a complete frame clear and x-out-of-range drops.
module tb_pixel_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_clear = 1'b0, m_valid = 1'b0, m_last = 1'b0;
  logic [19:0] m_pixel = '0;
  logic [23:0] m_color = '0;
  logic        m_ready, m_we, m_done, m_busy;
  logic [11:0] m_addr;
  logic [23:0] m_data;

  logic        s_clear = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [19:0] s_pixel = '0;
  logic [23:0] s_color = '0;
  logic        s_ready, s_we, s_done, s_busy;
  logic [2:0]  s_addr;
  logic [23:0] s_data;

  pixel_writer #(.WIDTH(1024), .HEIGHT(4), .FIFO_DEPTH(16), .CLEAR_COLOR(24'h123456)) dut_m (
    .clk_in(clk), .rst_in(rst_n), .clear_in(m_clear), .valid_in(m_valid),
    .pixel_in(m_pixel), .color_in(m_color), .last_in(m_last), .ready_out(m_ready),
    .addr_out(m_addr), .data_out(m_data), .we_out(m_we), .done_out(m_done), .busy_out(m_busy)
  );

  pixel_writer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(16), .CLEAR_COLOR(24'hABCDEF)) dut_s (
    .clk_in(clk), .rst_in(rst_n), .clear_in(s_clear), .valid_in(s_valid),
    .pixel_in(s_pixel), .color_in(s_color), .last_in(s_last), .ready_out(s_ready),
    .addr_out(s_addr), .data_out(s_data), .we_out(s_we), .done_out(s_done), .busy_out(s_busy)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [23:0] data;
    logic        done;
    logic [31:0] cyc;
  } wr_t;

  wr_t mq[$];
  wr_t sq[$];
  int  m_drop_done = 0;
  int  s_drop_done = 0;

  // Write/done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (m_we) mq.push_back({m_addr, m_data, m_done, 32'(cyc)});
    else if (m_done) m_drop_done++;
    if (s_we) sq.push_back({12'(s_addr), s_data, s_done, 32'(cyc)});
    else if (s_done) s_drop_done++;
  end

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] color;
    logic        last;
    logic        exp_we;
    logic [11:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_m(input logic [9:0] x, input logic [9:0] y, input logic [23:0] c,
                        input logic l, input int budget);
    int k = 0;
    m_valid = 1'b1; m_pixel = {x, y}; m_color = c; m_last = l;
    while (!m_ready && k < budget) begin
      step(1);
      k++;
    end
    if (!m_ready) check("push_m_timeout", 32'(m_ready), 32'd1);
    step(1);
    m_valid = 1'b0;
  endtask

  task automatic push_s(input logic [9:0] x, input logic [9:0] y, input logic [23:0] c,
                        input logic l);
    s_valid = 1'b1; s_pixel = {x, y}; s_color = c; s_last = l;
    if (!s_ready) check("push_s_ready", 32'(s_ready), 32'd1);
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle_m(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin
      step(1);
      k++;
    end
    check("m_idle_timeout", 32'(m_busy), 32'd0);
    step(2);
  endtask

  task automatic wait_idle_s(input int budget);
    int k = 0;
    while (s_busy && k < budget) begin
      step(1);
      k++;
    end
    check("s_idle_timeout", 32'(s_busy), 32'd0);
    step(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] hold_addr;
    int errs;
    int k;

    vecs[0] = '{10'd3,    10'd2,    24'hFF0000, 1'b1, 1'b1, 12'd2051};
    vecs[1] = '{10'd0,    10'd0,    24'h00FF00, 1'b0, 1'b1, 12'd0};
    vecs[2] = '{10'd1023, 10'd3,    24'h0000FF, 1'b1, 1'b1, 12'd4095};
    vecs[3] = '{10'd5,    10'd4,    24'h111111, 1'b1, 1'b0, 12'd0};
    vecs[4] = '{10'd1023, 10'd1023, 24'h222222, 1'b0, 1'b0, 12'd0};
    vecs[5] = '{10'd10,   10'd1,    24'hABCDEF, 1'b0, 1'b1, 12'd1034};
    vecs[6] = '{10'd0,    10'd1000, 24'h333333, 1'b1, 1'b0, 12'd0};

    // Reset asserted before any clock edge: outputs must clear asynchronously
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_we", 32'(m_we), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_addr", 32'(m_addr), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    step(2);
    check("rst_ready_hold", 32'(m_ready), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    step(2);

    // Single-pixel vectors
    hold_addr = 12'd0;
    for (int i = 0; i < 7; i++) begin
      mq.delete();
      m_drop_done = 0;
      push_m(vecs[i].x, vecs[i].y, vecs[i].color, vecs[i].last, 5);
      wait_idle_m(50);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_nwr", i), 32'(mq.size()), 32'd1);
        if (mq.size() == 1) begin
          check($sformatf("vec%0d_addr", i), 32'(mq[0].addr), 32'(vecs[i].exp_addr));
          check($sformatf("vec%0d_data", i), 32'(mq[0].data), 32'(vecs[i].color));
          check($sformatf("vec%0d_done", i), 32'(mq[0].done), 32'(vecs[i].last));
        end
        hold_addr = vecs[i].exp_addr;
      end else begin
        check($sformatf("vec%0d_nwr", i), 32'(mq.size()), 32'd0);
        check($sformatf("vec%0d_drop_done", i), 32'(m_drop_done), 32'(vecs[i].last));
      end
      check($sformatf("vec%0d_hold_addr", i), 32'(m_addr), 32'(hold_addr));
    end

    // Push/pop together at occupancy 1: A, gap, then B and C back-to-back
    mq.delete();
    push_m(10'd1, 10'd0, 24'h0000A1, 1'b0, 5);
    step(1);
    push_m(10'd2, 10'd0, 24'h0000B2, 1'b0, 5);
    push_m(10'd3, 10'd0, 24'h0000C3, 1'b1, 5);
    wait_idle_m(50);
    check("occ1_nwr", 32'(mq.size()), 32'd3);
    if (mq.size() == 3) begin
      check("occ1_a", 32'(mq[0].data), 32'h0000A1);
      check("occ1_b", 32'(mq[1].data), 32'h0000B2);
      check("occ1_c", 32'(mq[2].data), 32'h0000C3);
      check("occ1_done", {29'd0, mq[0].done, mq[1].done, mq[2].done}, 32'b001);
      check("occ1_c_addr", 32'(mq[2].addr), 32'd3);
    end

    // Full clear with 17 pixels offered meanwhile; FIFO fills at 16
    mq.delete();
    m_clear = 1'b1;
    step(1);
    m_clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_m(10'(i), 10'd3, 24'hC00000 | 24'(i), (i == 15), 5);
    end
    check("full_ready", 32'(m_ready), 32'd0);
    check("full_busy", 32'(m_busy), 32'd1);
    push_m(10'd100, 10'd0, 24'hDDDDDD, 1'b1, 6000);
    wait_idle_m(200);
    check("clr_nwr", 32'(mq.size()), 32'd4113);
    if (mq.size() == 4113) begin
      errs = 0;
      for (int i = 0; i < 4096; i++) begin
        if (mq[i].addr != 12'(i) || mq[i].data != 24'h123456 || mq[i].cyc != mq[0].cyc + 32'(i))
          errs++;
      end
      check("clr_sweep_errs", 32'(errs), 32'd0);
      errs = 0;
      for (int j = 0; j < 16; j++) begin
        if (mq[4096+j].addr != 12'(3072 + j) || mq[4096+j].data != (24'hC00000 | 24'(j)) ||
            mq[4096+j].done != (j == 15))
          errs++;
      end
      check("clr_order_errs", 32'(errs), 32'd0);
      check("clr_17_addr", 32'(mq[4112].addr), 32'd100);
      check("clr_17_data", 32'(mq[4112].data), 32'hDDDDDD);
      check("clr_17_done", 32'(mq[4112].done), 32'd1);
    end

    // Reset while draining with 5 entries still queued
    mq.delete();
    m_clear = 1'b1;
    step(1);
    m_clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_m(10'(i), 10'd0, 24'hE00000 | 24'(i), 1'b1, 5);
    end
    k = 0;
    while (mq.size() < 4097 && k < 6000) begin
      step(1);
      k++;
    end
    check("rstd_reach_drain", 32'(mq.size() >= 4097), 32'd1);
    check("rstd_we_before", 32'(m_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstd_we", 32'(m_we), 32'd0);
    check("rstd_busy", 32'(m_busy), 32'd0);
    check("rstd_ready", 32'(m_ready), 32'd1);
    check("rstd_addr", 32'(m_addr), 32'd0);
    step(1);
    rst_n = 1'b1;
    mq.delete();
    step(20);
    check("rstd_no_writes", 32'(mq.size()), 32'd0);
    check("rstd_busy_after", 32'(m_busy), 32'd0);

    // 4x2 clear; a second clear pulse mid-sweep is ignored
    sq.delete();
    s_clear = 1'b1;
    step(1);
    s_clear = 1'b0;
    step(3);
    s_clear = 1'b1;
    step(1);
    s_clear = 1'b0;
    wait_idle_s(50);
    check("s_clr_nwr", 32'(sq.size()), 32'd8);
    if (sq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("s_clr%0d_addr", i), 32'(sq[i].addr), 32'(i));
        check($sformatf("s_clr%0d_data", i), 32'(sq[i].data), 32'hABCDEF);
        check($sformatf("s_clr%0d_cyc", i), sq[i].cyc - sq[0].cyc, 32'(i));
      end
    end

    // x one past the right edge is dropped (x=1024 is not encodable in 10 bits)
    sq.delete();
    s_drop_done = 0;
    push_s(10'd4, 10'd0, 24'hFFFFFF, 1'b1);
    push_s(10'd3, 10'd1, 24'h777777, 1'b0);
    wait_idle_s(50);
    check("s_drop_done", 32'(s_drop_done), 32'd1);
    check("s_edge_nwr", 32'(sq.size()), 32'd1);
    if (sq.size() == 1) begin
      check("s_edge_addr", 32'(sq[0].addr), 32'd7);
      check("s_edge_data", 32'(sq[0].data), 32'h777777);
      check("s_edge_done", 32'(sq[0].done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
